// File: rtl/stage_4_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, load-op codes,
// FSM state codes and the packed layouts of the stage buses.
package stage_4_mem_pkg;

    localparam int STAGE34_W = 74;
    localparam int STAGE45_W = 70;
    localparam int FWD_W     = 38;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  dest;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } s34_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } s45_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } fwd_t;

endpackage

// File: rtl/stage_4_mem_load_align.sv
// Load data aligner: picks the addressed byte/half from the read word and
// sign- or zero-extends it. Purely combinational.
module mem_load_align
    import stage_4_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_op,
    output logic [31:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (ld_op)
            LD_B:    aligned = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   aligned = {24'd0, byte_sel};
            LD_H:    aligned = {{16{half_sel[15]}}, half_sel};
            LD_HU:   aligned = {16'd0, half_sel};
            default: aligned = raw;
        endcase
    end

endmodule

// File: rtl/stage_4_mem.sv
// MEM pipeline stage: latches the EX bus, waits for the load response and
// builds the WB and forwarding buses. Define MEM_SUBWORD_LOAD_EN for byte/half loads.
module stage_4_mem
    import stage_4_mem_pkg::*;
#(
    parameter int IN_W  = STAGE34_W,
    parameter int OUT_W = STAGE45_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_3,
    output logic             allow_4,
    output logic             valid_4,
    input  logic             allow_5,
    input  logic [IN_W-1:0]  stage_3_to_4,
    input  logic [31:0]      data_sram_rdata,
    input  logic             data_sram_data_ok,
    output logic [OUT_W-1:0] stage_4_to_5,
    output logic [FWD_W-1:0] fwd_4
);

    s34_t        in_bus;
    s34_t        in_r;
    logic        valid_r;
    mem_state_e  state;
    logic [31:0] rdata_buf;
    logic        ready_go;
    logic [31:0] raw;
    logic [31:0] load_data;
    logic [31:0] final_result;
    s45_t        out_bus;
    fwd_t        fwd_bus;

    assign in_bus = s34_t'(stage_3_to_4);

    // A load is only ever in WAIT or HOLD; non-loads never wait.
    assign ready_go = !in_r.res_from_mem
                   || (state == S_WAIT && data_sram_data_ok)
                   || (state == S_HOLD);

    assign allow_4 = !valid_r || (ready_go && allow_5);
    assign valid_4 = valid_r && ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_r      <= '0;
            valid_r   <= 1'b0;
            state     <= S_IDLE;
            rdata_buf <= '0;
        end else begin
            if (allow_4)
                valid_r <= valid_3;
            if (valid_3 && allow_4)
                in_r <= in_bus;
            // allow_4 low in WAIT with data_ok can only mean WB is stalling.
            if (allow_4) begin
                state <= (valid_3 && in_bus.res_from_mem) ? S_WAIT : S_IDLE;
            end else if (state == S_WAIT && data_sram_data_ok) begin
                state     <= S_HOLD;
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign raw = (state == S_HOLD) ? rdata_buf : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
    mem_load_align u_align (
        .raw     (raw),
        .addr_lo (in_r.alu_result[1:0]),
        .ld_op   (in_r.ld_op),
        .aligned (load_data)
    );
`else
    logic unused_ld_op;
    assign unused_ld_op = ^in_r.ld_op;
    assign load_data    = raw;
`endif

    assign final_result = in_r.res_from_mem ? load_data : in_r.alu_result;

    assign out_bus.rf_we        = in_r.rf_we;
    assign out_bus.dest         = in_r.dest;
    assign out_bus.final_result = final_result;
    assign out_bus.pc           = in_r.pc;
    assign stage_4_to_5         = out_bus;

    assign fwd_bus.we   = valid_r && in_r.rf_we;
    assign fwd_bus.dest = in_r.dest;
    assign fwd_bus.data = final_result;
    assign fwd_4        = fwd_bus;

endmodule

// File: tb/tb_stage_4_mem.sv
// Self-checking bench for stage_4_mem: directed sequences, a sub-word vector
// table and a randomized run against a slot-level reference model.
module tb_stage_4_mem;
    import stage_4_mem_pkg::*;

`ifdef MEM_SUBWORD_LOAD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_3;
    logic        allow_4;
    logic        valid_4;
    logic        allow_5;
    s34_t        s3;
    logic [31:0] rdata;
    logic        data_ok;
    logic [69:0] stage_4_to_5;
    logic [37:0] fwd_4;

    int n_cmp = 0;
    int n_bad = 0;

    stage_4_mem dut (
        .clk               (clk),
        .reset             (reset),
        .valid_3           (valid_3),
        .allow_4           (allow_4),
        .valid_4           (valid_4),
        .allow_5           (allow_5),
        .stage_3_to_4      (s3),
        .data_sram_rdata   (rdata),
        .data_sram_data_ok (data_ok),
        .stage_4_to_5      (stage_4_to_5),
        .fwd_4             (fwd_4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic s34_t mk(input logic we, input logic [4:0] d, input logic m,
                                input logic [2:0] op, input logic [31:0] alu, input logic [31:0] pc);
        s34_t r;
        r.rf_we = we; r.dest = d; r.res_from_mem = m; r.ld_op = op;
        r.alu_result = alu; r.pc = pc;
        return r;
    endfunction

    // Reference load extension, computed from shifts and masks.
    function automatic logic [31:0] ext(input logic [31:0] raw_w, input logic [2:0] op, input logic [1:0] a);
        logic [31:0] b, h;
        b = (raw_w >> (8 * a)) & 32'hFF;
        h = (raw_w >> (16 * a[1])) & 32'hFFFF;
        if (!SUBWORD) return raw_w;
        case (op)
            LD_B:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            LD_BU:   return b;
            LD_H:    return h[15] ? (h | 32'hFFFF_0000) : h;
            LD_HU:   return h;
            default: return raw_w;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  addr;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    // Reference model: one slot holding the instruction and its response, if any.
    logic        m_valid;
    s34_t        m_ins;
    logic        m_got;
    logic [31:0] m_data;
    int          resp;

    task automatic model_step();
        logic ld, pend, done, ev4, ea4;
        logic [31:0] rw, fin;
        ld   = m_ins.res_from_mem;
        pend = m_valid && ld && !m_got;
        done = !ld || m_got || (pend && data_ok);
        ev4  = m_valid && done;
        ea4  = !m_valid || (done && allow_5);
        rw   = m_got ? m_data : rdata;
        fin  = ld ? ext(rw, m_ins.ld_op, m_ins.alu_result[1:0]) : m_ins.alu_result;
        chk("rnd_valid_4", valid_4, ev4);
        chk("rnd_allow_4", allow_4, ea4);
        chk("rnd_fwd_we_dest", fwd_4[37:32], {m_valid && m_ins.rf_we, m_ins.dest});
        if (ev4) begin
            chk("rnd_out_bus", stage_4_to_5, {m_ins.rf_we, m_ins.dest, fin, m_ins.pc});
            chk("rnd_fwd_data", fwd_4[31:0], fin);
        end
        if (ea4) begin
            m_valid = valid_3;
            if (valid_3) begin
                m_ins = s3;
                m_got = 1'b0;
                if (s3.res_from_mem) resp = $urandom_range(1, 3);
            end
        end else if (pend && data_ok) begin
            m_got  = 1'b1;
            m_data = rdata;
        end
    endtask

    initial begin
        tbl[0] = '{LD_B,  2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
        tbl[1] = '{LD_BU, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
        tbl[2] = '{LD_H,  2'd2, 32'h80FF_7F01, 32'hFFFF_80FF};
        tbl[3] = '{LD_HU, 2'd0, 32'h80FF_7F01, 32'h0000_7F01};
        tbl[4] = '{LD_B,  2'd1, 32'h80FF_7F01, 32'h0000_007F};
        tbl[5] = '{LD_BU, 2'd2, 32'h80FF_7F01, 32'h0000_00FF};
        tbl[6] = '{LD_B,  2'd0, 32'h80FF_7F01, 32'h0000_0001};
        tbl[7] = '{LD_H,  2'd0, 32'h80FF_7F01, 32'h0000_7F01};
        tbl[8] = '{LD_W,  2'd2, 32'h80FF_7F01, 32'h80FF_7F01};
        tbl[9] = '{3'd7,  2'd1, 32'h80FF_7F01, 32'h80FF_7F01};

        reset = 1'b1; valid_3 = 1'b0; allow_5 = 1'b1; data_ok = 1'b0; rdata = '0; s3 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid_4", valid_4, 1'b0);
        chk("rst_allow_4", allow_4, 1'b1);
        chk("rst_out_bus", stage_4_to_5, '0);
        chk("rst_fwd", fwd_4, '0);
        @(negedge clk) reset = 1'b0;

        // Non-load bypass
        @(negedge clk) valid_3 = 1'b1; s3 = mk(1, 5'd5, 0, LD_W, 32'h1234_5678, 32'h100);
        #1 chk("byp_allow_4", allow_4, 1'b1);
        @(negedge clk) valid_3 = 1'b0;
        #1;
        chk("byp_valid_4", valid_4, 1'b1);
        chk("byp_out_bus", stage_4_to_5, {1'b1, 5'd5, 32'h1234_5678, 32'h100});
        chk("byp_fwd", fwd_4, {1'b1, 5'd5, 32'h1234_5678});
        @(negedge clk) #1 chk("byp_drain", valid_4, 1'b0);

        // Word load, response two cycles after it enters
        @(negedge clk) valid_3 = 1'b1; s3 = mk(1, 5'd7, 1, LD_W, 32'h1000, 32'h104);
        @(negedge clk) valid_3 = 1'b0;
        #1 chk("wl_wait1", {valid_4, allow_4, fwd_4[37]}, 3'b001);
        @(negedge clk) data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("wl_done_hs", {valid_4, allow_4}, 2'b11);
        chk("wl_done_out", stage_4_to_5, {1'b1, 5'd7, 32'hDEAD_BEEF, 32'h104});
        @(negedge clk) data_ok = 1'b0;
        #1 chk("wl_drain", valid_4, 1'b0);

        // WB stall while the response arrives
        @(negedge clk) valid_3 = 1'b1; s3 = mk(1, 5'd9, 1, LD_W, 32'h2000, 32'h108);
        @(negedge clk) valid_3 = 1'b0; allow_5 = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
        #1 chk("hold_cap_hs", {valid_4, allow_4}, 2'b10);
        @(negedge clk) data_ok = 1'b0; rdata = 32'h1111_1111;
        #1 chk("hold_keep", {valid_4, allow_4, stage_4_to_5[63:32]}, {2'b10, 32'hCAFE_F00D});
        @(negedge clk) data_ok = 1'b1; rdata = 32'h2222_2222;
        #1 chk("hold_stray_ok", stage_4_to_5[63:32], 32'hCAFE_F00D);
        @(negedge clk) data_ok = 1'b0; allow_5 = 1'b1;
        #1 chk("hold_release", {valid_4, allow_4, stage_4_to_5[63:32]}, {2'b11, 32'hCAFE_F00D});
        @(negedge clk) #1 chk("hold_drain", valid_4, 1'b0);

        // Sub-word vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) valid_3 = 1'b1;
            s3 = mk(1, 5'd1, 1, tbl[i].op, {30'h40, tbl[i].addr}, 32'h200 + 4 * i);
            @(negedge clk) valid_3 = 1'b0; data_ok = 1'b1; rdata = tbl[i].rd;
            #1 chk($sformatf("vec%0d", i), {valid_4, stage_4_to_5[63:32]},
                   {1'b1, SUBWORD ? tbl[i].exp : tbl[i].rd});
            @(negedge clk) data_ok = 1'b0;
        end

        // Reset while a load is pending, then a stray response
        @(negedge clk) valid_3 = 1'b1; s3 = mk(1, 5'd11, 1, LD_W, 32'h3000, 32'h300);
        @(negedge clk) valid_3 = 1'b0;
        #1 chk("rw_wait", valid_4, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        #1 chk("rw_after_rst", {valid_4, allow_4, stage_4_to_5}, {2'b01, 70'd0});
        @(negedge clk) data_ok = 1'b1; rdata = 32'h5555_AAAA;
        #1 chk("rw_stray", {valid_4, stage_4_to_5, fwd_4}, {1'b0, 70'd0, 38'd0});
        @(negedge clk) data_ok = 1'b0;

        // Back-to-back loads
        @(negedge clk) valid_3 = 1'b1; s3 = mk(1, 5'd3, 1, LD_W, 32'h400, 32'h400);
        @(negedge clk) s3 = mk(1, 5'd4, 1, LD_W, 32'h404, 32'h404); data_ok = 1'b1; rdata = 32'hAAAA_0001;
        #1 chk("b2b_first", {valid_4, allow_4, stage_4_to_5}, {2'b11, 1'b1, 5'd3, 32'hAAAA_0001, 32'h400});
        @(negedge clk) valid_3 = 1'b0; rdata = 32'hBBBB_0002;
        #1 chk("b2b_second", {valid_4, allow_4, stage_4_to_5}, {2'b11, 1'b1, 5'd4, 32'hBBBB_0002, 32'h404});
        @(negedge clk) data_ok = 1'b0;
        #1 chk("b2b_drain", valid_4, 1'b0);

        // Randomized run against the slot model
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        m_valid = 1'b0; m_ins = '0; m_got = 1'b0; m_data = '0; resp = -1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            data_ok = 1'b0;
            if (resp > 0) begin
                resp--;
                if (resp == 0) begin
                    data_ok = 1'b1;
                    resp = -1;
                end
            end else if ($urandom % 8 == 0) begin
                data_ok = 1'b1;
            end
            rdata   = $urandom;
            valid_3 = ($urandom % 3) != 0;
            allow_5 = ($urandom % 4) != 0;
            s3 = mk($urandom % 2 == 0, 5'($urandom), $urandom % 2 == 0,
                    3'($urandom_range(0, 7)), $urandom, $urandom);
            #1 model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
